// File: rtl/pulse_train_if.sv
// pulse_train_if
//   Bundles the control/config inputs and the status outputs of the
//   pulse-train transmitter.
//
//   Handshake: there is no valid/ready pair. The master raises 'start' for
//   one or more cycles. The slave samples start only while idle. While
//   idle it also samples num_pulses/high_cycles/low_cycles, in the same
//   cycle as start. 'abort' is a level, sampled each cycle while a train
//   is running. Every status signal is a registered level or a one-cycle
//   pulse driven by the slave.
//
//   Signals:
//     start        master->slave  request to begin a train
//     abort        master->slave  stop the running train
//     num_pulses   master->slave  N, pulses per train
//     high_cycles  master->slave  H, cycles high per pulse
//     low_cycles   master->slave  L, cycles low between pulses
//     pulse_out    slave->master  registered pulse-train output
//     busy         slave->master  train in progress
//     done         slave->master  one-cycle pulse on normal completion
//     cfg_err      slave->master  one-cycle pulse on rejected start
//     pulses_sent  slave->master  completed pulses in current/last train
interface pulse_train_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_pulses;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] low_cycles;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic [CNT_W-1:0] pulses_sent;

  modport master (
    output start, abort, num_pulses, high_cycles, low_cycles,
    input  pulse_out, busy, done, cfg_err, pulses_sent
  );

  modport slave (
    input  start, abort, num_pulses, high_cycles, low_cycles,
    output pulse_out, busy, done, cfg_err, pulses_sent
  );
endinterface

// File: rtl/pulse_train_tx.sv
// pulse_train_tx
//   Programmable pulse-train transmitter. A start request with nonzero
//   N/H/L produces N pulses, each H cycles high, separated by L cycles low.
//   The last pulse has no trailing low phase. Completion is reported with a
//   one-cycle 'done'. Each falling edge of pulse_out is one downstream
//   event, so the number of falling edges seen on a normally completed
//   train equals pulses_sent.
//
//   Ports:
//     clk      in   rising-edge clock
//     reset    in   asynchronous, active-low reset
//     bus      if   pulse_train_if.slave (start/abort/config in, status out)
//     state_o  out  current FSM state (IDLE=0, HIGH=1, LOW=2, DONE=3)
module pulse_train_tx #(
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  pulse_train_if.slave   bus,
  output logic [1:0]     state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO = '0;

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] timer_q,   timer_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [CNT_W-1:0] n_q,       n_d;
  logic [CNT_W-1:0] h_q,       h_d;
  logic [CNT_W-1:0] l_q,       l_d;
  logic             pulse_q,   pulse_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic             cfg_err_q, cfg_err_d;

  logic [CNT_W-1:0] count_inc;
  logic             cfg_ok;

  assign count_inc = count_q + ONE;
  assign cfg_ok    = (bus.num_pulses  != ZERO) &&
                     (bus.high_cycles != ZERO) &&
                     (bus.low_cycles  != ZERO);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    count_d   = count_q;
    n_d       = n_q;
    h_d       = h_q;
    l_d       = l_q;
    pulse_d   = pulse_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        // abort is ignored here, so start always wins over a concurrent abort
        if (bus.start) begin
          if (cfg_ok) begin
            n_d     = bus.num_pulses;
            h_d     = bus.high_cycles;
            l_d     = bus.low_cycles;
            count_d = ZERO;
            timer_d = bus.high_cycles - ONE;
            pulse_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_HIGH;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ST_HIGH: begin
        if (bus.abort) begin
          // The pulse is cut short; it is not counted as completed.
          pulse_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (timer_q == ZERO) begin
          count_d = count_inc;
          pulse_d = 1'b0;
          if (count_inc == n_q) begin
            // Last pulse: no trailing low phase, report completion now.
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            timer_d = l_q - ONE;
            state_d = ST_LOW;
          end
        end else begin
          timer_d = timer_q - ONE;
        end
      end

      ST_LOW: begin
        if (bus.abort) begin
          pulse_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (timer_q == ZERO) begin
          timer_d = h_q - ONE;
          pulse_d = 1'b1;
          state_d = ST_HIGH;
        end else begin
          timer_d = timer_q - ONE;
        end
      end

      ST_DONE: begin
        // One-cycle completion state; start and abort are both ignored.
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      count_q   <= '0;
      n_q       <= '0;
      h_q       <= '0;
      l_q       <= '0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      n_q       <= n_d;
      h_q       <= h_d;
      l_q       <= l_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.pulse_out   = pulse_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cfg_err     = cfg_err_q;
  assign bus.pulses_sent = count_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_pulse_train_tx.sv
module tb_pulse_train_tx;

  localparam int CNT_W = 8;
  localparam int W     = 4 + CNT_W;  // {pulse_out, busy, done, cfg_err, pulses_sent}

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic [1:0] state_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pulse_train_if #(.CNT_W(CNT_W)) bus_if ();

  pulse_train_tx #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .state_o (state_o)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int fall_cnt = 0;
  int sent_model = 0;
  string cur_tag = "reset";

  always @(negedge bus_if.pulse_out) fall_cnt++;

  function automatic logic [W-1:0] observed();
    return {bus_if.pulse_out, bus_if.busy, bus_if.done, bus_if.cfg_err, bus_if.pulses_sent};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulses whose falling edge has happened by cycle offset j of a train.
  function automatic int completed(int j, int h, int l);
    int i, r;
    if (j < 0) return 0;
    i = j / (h + l);
    r = j % (h + l);
    return (r >= h) ? i + 1 : i;
  endfunction

  // Expected output per edge k+j of a train started at edge k.
  // abort_at >= 0 means abort is sampled at edge k+abort_at.
  task automatic push_train(input int n, input int h, input int l, input int abort_at);
    int t;
    int r;
    t = n * h + (n - 1) * l;
    for (int j = 0; j <= t + 1; j++) begin
      if (abort_at >= 0 && j == abort_at) begin
        exp_q.push_back({4'b0000, CNT_W'(completed(j - 1, h, l))});
        sent_model = completed(j - 1, h, l);
        return;
      end
      r = j % (h + l);
      if (j < t)
        exp_q.push_back({(r < h), 1'b1, 2'b00, CNT_W'(completed(j, h, l))});
      else if (j == t)
        exp_q.push_back({4'b0010, CNT_W'(n)});
      else
        exp_q.push_back({4'b0000, CNT_W'(n)});
    end
    sent_model = n;
  endtask

  task automatic compare_one();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%h expected=<empty queue>", cur_tag, observed());
    end else begin
      chk(cur_tag, observed(), exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic launch(input int n, input int h, input int l);
    bus_if.num_pulses  = CNT_W'(n);
    bus_if.high_cycles = CNT_W'(h);
    bus_if.low_cycles  = CNT_W'(l);
    bus_if.start       = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    compare_one();
  endtask

  // poke: toggle start randomly while running, forcing it high on the last cycle.
  task automatic compare_cycles(input int cnt, input bit poke);
    for (int k = 0; k < cnt; k++) begin
      if (poke) bus_if.start = (k == cnt - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      compare_one();
    end
    bus_if.start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rn, rh, rl;
    reset              = 1'b0;
    bus_if.start       = 1'b0;
    bus_if.abort       = 1'b0;
    bus_if.num_pulses  = '0;
    bus_if.high_cycles = '0;
    bus_if.low_cycles  = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", observed(), '0);
    chk("reset_state", W'(state_o), W'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // N=3 H=2 L=1: 1,1,0,1,1,0,1,1,0 then done at edge 8
    cur_tag = "train_3_2_1";
    fall_cnt = 0;
    push_train(3, 2, 1, -1);
    launch(3, 2, 1);
    compare_cycles(9, 1'b0);
    chk("falls_3_2_1", W'(fall_cnt), W'(3));

    // N=1 H=1 L=5: single one-cycle pulse, L unused
    cur_tag = "train_1_1_5";
    push_train(1, 1, 5, -1);
    launch(1, 1, 5);
    compare_cycles(2, 1'b0);

    // Rejected start: N=0
    cur_tag = "cfg_err";
    exp_q.push_back({4'b0001, CNT_W'(sent_model)});
    exp_q.push_back({4'b0000, CNT_W'(sent_model)});
    launch(0, 4, 4);
    compare_cycles(1, 1'b0);

    // Rejected start: L=0
    cur_tag = "cfg_err_l0";
    exp_q.push_back({4'b0001, CNT_W'(sent_model)});
    exp_q.push_back({4'b0000, CNT_W'(sent_model)});
    launch(3, 2, 0);
    compare_cycles(1, 1'b0);

    // Abort during the third pulse's high phase (high at offsets 12..14)
    cur_tag = "abort_4_3_3";
    push_train(4, 3, 3, 13);
    launch(4, 3, 3);
    compare_cycles(12, 1'b0);
    bus_if.abort = 1'b1;
    compare_cycles(1, 1'b0);
    bus_if.abort = 1'b0;

    // Start accepted one cycle after the abort; start pulsed during the train and DONE
    cur_tag = "restart_poke";
    push_train(2, 1, 2, -1);
    exp_q.push_back({4'b0000, CNT_W'(2)});
    launch(2, 1, 2);
    compare_cycles(5, 1'b1);
    compare_cycles(1, 1'b0);

    // Abort during LOW phase
    cur_tag = "abort_low";
    push_train(3, 2, 4, 4);
    launch(3, 2, 4);
    compare_cycles(3, 1'b0);
    bus_if.abort = 1'b1;
    compare_cycles(1, 1'b0);
    bus_if.abort = 1'b0;

    // Start and abort together in IDLE: start wins; random small config
    cur_tag = "rand_start_abort";
    rn = $urandom_range(1, 4);
    rh = $urandom_range(1, 3);
    rl = $urandom_range(1, 3);
    push_train(rn, rh, rl, -1);
    bus_if.abort = 1'b1;
    launch(rn, rh, rl);
    bus_if.abort = 1'b0;
    compare_cycles(rn * rh + (rn - 1) * rl + 1, 1'b0);

    // Asynchronous reset in the middle of a HIGH phase
    cur_tag = "pre_reset";
    push_train(5, 4, 1, -1);
    launch(5, 4, 1);
    compare_cycles(2, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", observed(), '0);
    chk("async_reset_state", W'(state_o), W'(0));
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;

    // Longest train: N=255 H=1 L=1, done at edge 509
    cur_tag = "train_255_1_1";
    fall_cnt = 0;
    push_train(255, 1, 1, -1);
    launch(255, 1, 1);
    compare_cycles(510, 1'b0);
    chk("falls_255", W'(fall_cnt), W'(255));
    chk("queue_drained", W'(exp_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
